// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - states, segment codes and BCD limit shared by the reaction game
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_RAND = 3'd2,
    WAIT_USER = 3'd3,
    SHOW      = 3'd4,
    FAULT     = 3'd5,
    SUMMARY   = 3'd6
  } state_t;

  localparam logic [24:0] BLANK     = 25'h1FFFFFF;
  localparam logic [24:0] FAULT_MSG = 25'h0E38E3F;
  localparam logic [63:0] BCD_MAX   = {16{4'h9}};

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - 2-flop synchroniser with a one-cycle edge pulse per bit
module edge_sync #(
  parameter int         W    = 1,
  parameter bit         RISE = 1'b1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] pulse
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= INIT;
      s2 <= INIT;
      s3 <= INIT;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign pulse = RISE ? (s2 & ~s3) : (~s2 & s3);

endmodule

// File: rtl/reaction_game_ctrl.sv
// rtl/reaction_game_ctrl.sv - multi-round reaction game FSM driving counter reset, LEDs and display
module reaction_game_ctrl
  import game_pkg::*;
#(
  parameter int N_SW    = 10,
  parameter int CNT_W   = 20,
  parameter int RAND_W  = 15,
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_n,
  input  logic [N_SW-1:0]   sw,
  input  logic [RAND_W-1:0] rand_num,
  input  logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  count_binary,
  input  logic [24:0]       go_msg,
  output logic              clreset,
  output logic [25:0]       display,
  output logic [N_SW-1:0]   led,
  output logic              false_start,
  output logic [3:0]        round_idx
);

  localparam logic [CNT_W-1:0] BCD_ALL9   = BCD_MAX[CNT_W-1:0];
  localparam logic [3:0]       TGT_LAST   = 4'(N_SW - 1);
  localparam logic [3:0]       ROUND_LAST = 4'(ROUNDS - 1);
  localparam logic [N_SW-1:0]  LED_ONE    = {{(N_SW-1){1'b0}}, 1'b1};

  state_t              state, state_d;
  logic                start, start_lvl_unused;
  logic [N_SW-1:0]     sw_s, sw_rise;
  logic [RAND_W-1:0]   rand_q, rand_d;
  logic [3:0]          tgt_idx, tgt_d, round_d;
  logic [CNT_W-1:0]    last_q, last_d, best_q, best_d;
  logic                clreset_d, false_start_d;
  logic [25:0]         display_d;
  logic [N_SW-1:0]     led_d;
  logic                rand_hit, timeout, user_hit;

  edge_sync #(.W(1), .RISE(1'b0), .INIT(1'b1)) u_start_sync (
    .clk(clk), .rst(rst), .d(start_n), .level(start_lvl_unused), .pulse(start)
  );

  edge_sync #(.W(N_SW), .RISE(1'b1), .INIT('0)) u_sw_sync (
    .clk(clk), .rst(rst), .d(sw), .level(sw_s), .pulse(sw_rise)
  );

  // While clreset is still high the counter value is stale, so neither compare may fire.
  assign rand_hit = !clreset && (32'(count_binary) == 32'(rand_q));
  assign timeout  = !clreset && (32'(count_binary) >= 32'(TIMEOUT));
  assign user_hit = sw_rise[tgt_idx];

  always_comb begin
    state_d       = state;
    rand_d        = rand_q;
    tgt_d         = tgt_idx;
    round_d       = round_idx;
    last_d        = last_q;
    best_d        = best_q;
    clreset_d     = 1'b1;
    display_d     = {1'b0, BLANK};
    led_d         = '0;
    false_start_d = 1'b0;
    case (state)
      IDLE: begin
        display_d = {1'b0, go_msg};
        if (start) begin
          round_d = '0;
          best_d  = BCD_ALL9;
          state_d = ARM;
        end
      end
      ARM: begin
        if (sw_s == '0) begin
          rand_d  = rand_num;
          state_d = WAIT_RAND;
        end
      end
      WAIT_RAND: begin
        clreset_d = 1'b0;
        tgt_d     = (tgt_idx == TGT_LAST) ? 4'd0 : tgt_idx + 4'd1;
        if (start) begin
          state_d = ARM;
        end else if (sw_rise != '0) begin
          state_d = FAULT;
        end else if (rand_hit) begin
          tgt_d     = tgt_idx;
          clreset_d = 1'b1;
          state_d   = WAIT_USER;
        end
      end
      WAIT_USER: begin
        clreset_d = 1'b0;
        led_d     = LED_ONE << tgt_idx;
        if (start) begin
          state_d = ARM;
        end else if (user_hit) begin
          last_d  = count;
          state_d = SHOW;
        end else if (timeout) begin
          last_d  = BCD_ALL9;
          state_d = SHOW;
        end
      end
      SHOW: begin
        display_d = {1'b1, 25'(last_q)};
        if (last_q < best_q) best_d = last_q;
        if (start) begin
          if (round_idx == ROUND_LAST) begin
            state_d = SUMMARY;
          end else begin
            round_d = round_idx + 4'd1;
            state_d = ARM;
          end
        end
      end
      FAULT: begin
        led_d         = '1;
        false_start_d = 1'b1;
        display_d     = {1'b0, FAULT_MSG};
        if (start) state_d = ARM;
      end
      SUMMARY: begin
        display_d = {1'b1, 25'(best_q)};
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rand_q      <= '0;
      tgt_idx     <= '0;
      round_idx   <= '0;
      last_q      <= '0;
      best_q      <= BCD_ALL9;
      clreset     <= 1'b1;
      display     <= {1'b0, BLANK};
      led         <= '0;
      false_start <= 1'b0;
    end else begin
      state       <= state_d;
      rand_q      <= rand_d;
      tgt_idx     <= tgt_d;
      round_idx   <= round_d;
      last_q      <= last_d;
      best_q      <= best_d;
      clreset     <= clreset_d;
      display     <= display_d;
      led         <= led_d;
      false_start <= false_start_d;
    end
  end

endmodule
